// File: rtl/instr_mem_sync_pkg.sv
// instr_mem_sync_pkg: shared FSM state encoding and default fill word
package instr_mem_sync_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int NOP_DEFAULT = 0;
endpackage

// File: rtl/instr_ram_1r1w.sv
// instr_ram_1r1w: one write port, one registered read port, write-first forwarding
module instr_ram_1r1w #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rnop,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // storage write; the array itself is never reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register: rnop substitutes the fill word, same-edge write wins over stored data
  always_ff @(posedge clk)
    if (rst) rdata <= RST_VAL;
    else if (re) rdata <= rnop ? RST_VAL : (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: instruction memory with clear sweep, stallable fetch and program port
module instr_mem_sync
  import instr_mem_sync_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 256,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_DEFAULT),
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              ready
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH-1);
  state_t state;
  logic [IDX_W-1:0] cnt, waddr;
  logic [DATA_W-1:0] wdata;
  logic fetch_ok, prog_ok, accept, we;
  // full-width range checks come before the index is truncated, so out-of-range never aliases
  assign fetch_ok = {1'b0, fetch_addr} < LIMIT;
  assign prog_ok = {1'b0, prog_addr} < LIMIT;
  assign accept = ready && !rst && fetch_req && !stall;
  assign we = !rst && (state == CLEAR || (ready && prog_we && prog_ok));
  assign waddr = state == CLEAR ? cnt : prog_addr[IDX_W-1:0];
  assign wdata = state == CLEAR ? NOP_VAL : prog_data;
  // clear/run sequencing plus fetch status flags, which freeze while stalled
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR_ON_RST != 0 ? CLEAR : RUN;
      cnt <= '0;
      ready <= 1'b0;
      inst_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state <= RUN;
          ready <= 1'b1;
        end
      end else ready <= 1'b1;
      if (!stall) begin
        inst_valid <= accept;
        addr_err <= accept && !fetch_ok;
      end
    end
  instr_ram_1r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .RST_VAL(NOP_VAL)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .re(accept),
    .rnop(!fetch_ok),
    .raddr(fetch_addr[IDX_W-1:0]),
    .rdata(inst)
  );
endmodule
